// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption core: one full cipher round per clock, with round keys
// generated on the fly from the previous round key.

module sbox_module (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward AES S-box; entry x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bitpos;

    assign bitpos = 11'd2047 - {a, 3'b000};
    assign y      = SBOX_TABLE[bitpos -: 8];
endmodule

module subbytes (
    input  logic [127:0] state,
    output logic [127:0] sub
);
    // Position-preserving: byte i in bits [127-8i -: 8] maps to the same slice.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sbox_module u_sbox (
            .a (state[127-8*i -: 8]),
            .y (sub[127-8*i -: 8])
        );
    end
endmodule

module aes128_round_engine #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);
    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    fsm_t         fsm;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [3:0]   round;
    logic [7:0]   rcon;

    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [127:0] next_key;
    logic [127:0] round_out;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the column-major state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   b0, b1, b2, b3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            b0 = xtime(a0);
            b1 = xtime(a1);
            b2 = xtime(a2);
            b3 = xtime(a3);
            o[127-32*c -: 8] = b0 ^ b1 ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ b1 ^ b2 ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ b2 ^ b3 ^ a3;
            o[103-32*c -: 8] = b0 ^ a0 ^ a1 ^ a2 ^ b3;
        end
        return o;
    endfunction

    subbytes u_subbytes (
        .state (state),
        .sub   (sb_out)
    );

    assign rot_word = {rkey[23:0], rkey[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        sbox_module u_key_sbox (
            .a (rot_word[31-8*k -: 8]),
            .y (sub_word[31-8*k -: 8])
        );
    end

    assign temp_word           = sub_word ^ {rcon, 24'h000000};
    assign next_key[127:96]    = rkey[127:96] ^ temp_word;
    assign next_key[95:64]     = rkey[95:64] ^ next_key[127:96];
    assign next_key[63:32]     = rkey[63:32] ^ next_key[95:64];
    assign next_key[31:0]      = rkey[31:0] ^ next_key[63:32];

    assign sr_out    = shift_rows(sb_out);
    assign mc_out    = mix_columns(sr_out);
    assign round_out = ((round == LAST) ? sr_out : mc_out) ^ next_key;

    // Accept loads the whitened plaintext; each RUN edge completes one round.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            state    <= '0;
            rkey     <= '0;
            round    <= '0;
            rcon     <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state <= data_in ^ key_in;
                        rkey  <= key_in;
                        round <= 4'd1;
                        rcon  <= 8'h01;
                        busy  <= 1'b1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    state <= round_out;
                    rkey  <= next_key;
                    round <= round + 4'd1;
                    rcon  <= xtime(rcon);
                    if (round == LAST) begin
                        data_out <= round_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
